// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit6=a .. bit0=g)
// and the capture FSM state encoding.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry n holds the pattern for hex value n.
  localparam logic [15:0][6:0] SEG_CODES = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_COUNT = 2'd1,
    S_HELD  = 2'd2
  } state_e;

endpackage

// File: rtl/seven_seg_encoder.sv
// Reverse segment lookup: active-low pattern back to a hex nibble.
module seven_seg_encoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_hit,
  output logic [3:0] o_hex,
  output logic       o_blank
);

  // Search the code table; codes are unique so at most one entry hits.
  always_comb begin
    o_hit = 1'b0;
    o_hex = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (i_seg == SEG_CODES[i]) begin
        o_hit = 1'b1;
        o_hex = 4'(i);
      end
    end
  end

  assign o_blank = (i_seg == SEG_BLANK);

endmodule

// File: rtl/seven_seg_capture.sv
// Snoops a multiplexed active-low 7-segment bus, debounces each anode slot
// and captures one decoded nibble per digit with valid flags.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic                    pattern_err
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]              r_seg_m, r_seg_s, r_seg_d;
  logic [NUM_DIGITS-1:0]   r_an_m,  r_an_s,  r_an_d;
  state_e                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_update;
  logic                    r_err;

  logic [NUM_DIGITS-1:0]   w_low;
  logic                    w_legal;
  logic                    w_same;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_hit;
  logic [3:0]              w_hex;
  logic                    w_blank;
  logic                    w_capture;

  // Two-flop synchronizers plus a delayed copy; idle display is all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_m <= '1;
      r_seg_s <= '1;
      r_seg_d <= '1;
      r_an_m  <= '1;
      r_an_s  <= '1;
      r_an_d  <= '1;
    end else begin
      r_seg_m <= seg;
      r_seg_s <= r_seg_m;
      r_seg_d <= r_seg_s;
      r_an_m  <= an;
      r_an_s  <= r_an_m;
      r_an_d  <= r_an_s;
    end
  end

  // A slot is legal only when exactly one anode is driven low.
  assign w_low   = ~r_an_s;
  assign w_legal = (w_low != '0) && ((w_low & (w_low - NUM_DIGITS'(1))) == '0);
  assign w_same  = (r_seg_s == r_seg_d) && (r_an_s == r_an_d);

  // Position of the active anode.
  always_comb begin
    w_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_low[i]) w_idx = IDX_W'(i);
    end
  end

  seven_seg_encoder u_enc (
    .i_seg   (r_seg_s),
    .o_hit   (w_hit),
    .o_hex   (w_hex),
    .o_blank (w_blank)
  );

  // Counter holds samples seen so far; the final matching sample captures
  // directly, so the counter never needs to store STABLE_CYCLES itself.
  assign w_capture = (r_state == S_COUNT) && w_same && w_legal && (r_cnt == CNT_LAST);

  // Stability FSM: WAIT -> COUNT -> HELD, one capture per stable window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_legal) begin
            r_cnt   <= CNT_W'(1);
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_same && w_legal) begin
            if (r_cnt == CNT_LAST) r_state <= S_HELD;
            else                   r_cnt   <= r_cnt + CNT_W'(1);
          end else if (w_legal) begin
            r_cnt <= CNT_W'(1);
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_HELD: begin
          if (!w_same) begin
            if (w_legal) begin
              r_cnt   <= CNT_W'(1);
              r_state <= S_COUNT;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  // Capture register file; clear is applied first so a same-cycle capture
  // result overrides it for the captured slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_valid  <= '0;
      r_update <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_update <= w_capture;
      if (clear) begin
        r_valid <= '0;
        r_err   <= 1'b0;
      end
      if (w_capture) begin
        if (w_hit) begin
          r_digits[4*w_idx +: 4] <= w_hex;
          r_valid[w_idx]         <= 1'b1;
        end else if (w_blank) begin
          r_valid[w_idx] <= 1'b0;
        end else begin
          r_valid[w_idx] <= 1'b0;
          r_err          <= 1'b1;
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_valid;
  assign update      = r_update;
  assign pattern_err = r_err;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: table of display windows plus hand-written
// clear/capture collision and mid-window reset sequences.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_i = 7'b1111111;
  logic [3:0]  an_i = 4'b1111;
  logic        clear_i = 1'b0;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        update;
  logic        pattern_err;

  seven_seg_capture #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg         (seg_i),
    .an          (an_i),
    .clear       (clear_i),
    .digits      (digits),
    .digit_valid (digit_valid),
    .update      (update),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  an;
    int          hold;
    bit          upd;
    logic [15:0] d;
    logic [15:0] dm;
    logic [3:0]  v;
    bit          e;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [15:0] dm;
    logic [3:0]  v;
    bit          e;
  } exp_t;

  vec_t vecs[13];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string nm, input logic [15:0] d, input logic [15:0] dm,
                           input logic [3:0] v, input bit e);
    if (dm != 16'h0) chk({nm, "_digits"}, 32'(digits & dm), 32'(d & dm));
    chk({nm, "_valid"}, 32'(digit_valid), 32'(v));
    chk({nm, "_err"}, 32'(pattern_err), 32'(e));
  endtask

  // One clock; on the falling edge pop the scoreboard when update is seen.
  task automatic tick(output bit upd);
    exp_t x;
    @(negedge clk);
    upd = 1'b0;
    if (rst_n && update) begin
      upd = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_unexpected_update", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        chk_state("sb", x.d, x.dm, x.v, x.e);
      end
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    bit u;
    int nup;
    string nm;
    nm = $sformatf("vec%0d", idx);
    seg_i = t.seg;
    an_i  = t.an;
    if (t.upd) sb.push_back('{t.d, t.dm, t.v, t.e});
    nup = 0;
    for (int c = 1; c <= t.hold; c++) begin
      tick(u);
      if (u) begin
        nup++;
        chk({nm, "_latency"}, 32'(c), 32'd6);
      end
    end
    chk({nm, "_upd_count"}, 32'(nup), t.upd ? 32'd1 : 32'd0);
    chk_state(nm, t.d, t.dm, t.v, t.e);
  endtask

  // Window where clear is raised exactly on the capture edge.
  task automatic clear_collide(input logic [6:0] s, input logic [3:0] a, input exp_t x,
                               input string nm);
    bit u;
    int nup;
    seg_i = s;
    an_i  = a;
    sb.push_back(x);
    nup = 0;
    for (int c = 1; c <= 8; c++) begin
      if (c == 6) clear_i = 1'b1;
      tick(u);
      clear_i = 1'b0;
      if (u) begin
        nup++;
        chk({nm, "_latency"}, 32'(c), 32'd6);
      end
    end
    chk({nm, "_upd_count"}, 32'(nup), 32'd1);
    chk_state(nm, x.d, x.dm, x.v, x.e);
  endtask

  initial begin
    bit u;
    int nup;

    //               seg         an       hold upd d         dm        v        e
    vecs[0]  = '{7'b0010010, 4'b1110, 10, 1'b1, 16'h0002, 16'hFFFF, 4'b0001, 1'b0};
    vecs[1]  = '{7'b1001111, 4'b0111,  8, 1'b1, 16'h1002, 16'hFFFF, 4'b1001, 1'b0};
    vecs[2]  = '{7'b0001000, 4'b1011,  8, 1'b1, 16'h1A02, 16'hFFFF, 4'b1101, 1'b0};
    vecs[3]  = '{7'b0000110, 4'b1101,  8, 1'b1, 16'h1A32, 16'hFFFF, 4'b1111, 1'b0};
    vecs[4]  = '{7'b0111000, 4'b1110,  8, 1'b1, 16'h1A3F, 16'hFFFF, 4'b1111, 1'b0};
    vecs[5]  = '{7'b0000000, 4'b1110,  3, 1'b0, 16'h1A3F, 16'hFFFF, 4'b1111, 1'b0};
    vecs[6]  = '{7'b0000000, 4'b1111,  8, 1'b0, 16'h1A3F, 16'hFFFF, 4'b1111, 1'b0};
    vecs[7]  = '{7'b1010101, 4'b1101,  8, 1'b1, 16'h1A3F, 16'hFFFF, 4'b1101, 1'b1};
    vecs[8]  = '{7'b0100100, 4'b1100,  8, 1'b0, 16'h1A3F, 16'hFFFF, 4'b1101, 1'b1};
    vecs[9]  = '{7'b0001111, 4'b1110,  8, 1'b1, 16'h1A37, 16'hFFFF, 4'b0001, 1'b0};
    vecs[10] = '{7'b1111111, 4'b1110,  8, 1'b1, 16'h0000, 16'h0000, 4'b0000, 1'b0};
    vecs[11] = '{7'b0000001, 4'b1110,  8, 1'b1, 16'h1A30, 16'hFFFF, 4'b0001, 1'b0};
    vecs[12] = '{7'b1010101, 4'b0111,  8, 1'b1, 16'h1A30, 16'hFFFF, 4'b0001, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_valid", 32'(digit_valid), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_err", 32'(pattern_err), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i <= 8; i++) run_vec(vecs[i], i);

    // Clear alone: flags drop, digits kept
    clear_i = 1'b1;
    tick(u);
    clear_i = 1'b0;
    chk("clear_upd", 32'(u), 32'd0);
    chk_state("clear", 16'h1A3F, 16'hFFFF, 4'b0000, 1'b0);

    for (int i = 9; i <= 12; i++) run_vec(vecs[i], i);

    // Clear on the capture edge: captured valid survives, err cleared
    clear_collide(7'b0000100, 4'b1011, '{16'h1930, 16'hFFFF, 4'b0100, 1'b0}, "clrcap_hex");
    // Clear on the capture edge of a bad pattern: err survives
    clear_collide(7'b1010101, 4'b1101, '{16'h1930, 16'hFFFF, 4'b0000, 1'b1}, "clrcap_err");

    // Reset in cycle 3 of a stable window; a full window is needed afterwards
    seg_i = 7'b0110000;
    an_i  = 4'b1110;
    sb.push_back('{16'h000E, 16'hFFFF, 4'b0001, 1'b0});
    tick(u);
    tick(u);
    rst_n = 1'b0;
    #1;
    chk("midrst_digits", 32'(digits), 32'd0);
    chk("midrst_valid", 32'(digit_valid), 32'd0);
    chk("midrst_update", 32'(update), 32'd0);
    chk("midrst_err", 32'(pattern_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nup = 0;
    for (int c = 1; c <= 8; c++) begin
      tick(u);
      if (u) begin
        nup++;
        chk("midrst_latency", 32'(c), 32'd6);
      end
    end
    chk("midrst_upd_count", 32'(nup), 32'd1);
    chk_state("midrst", 16'h000E, 16'hFFFF, 4'b0001, 1'b0);

    chk("sb_leftover", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on run time in case stimulus stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
